// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control interface.
// Groups the pipeline/cache status inputs and the pipeline register controls.
// The master side is the pipeline (it drives status and receives controls).
// The slave side is pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if;
  logic        ihit;
  logic        dhit;
  logic        mem_dreq;
  logic        mem_br_taken;
  logic        exe_jump;
  logic        exe_MemRd;
  logic [4:0]  exe_rt;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic        wb_halt;
  logic        pc_EN;
  logic        fd_EN;
  logic        de_EN;
  logic        em_EN;
  logic        mw_EN;
  logic        fd_flush;
  logic        de_flush;
  logic        em_flush;
  logic        halt;
  logic        stall_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output ihit, dhit, mem_dreq, mem_br_taken, exe_jump, exe_MemRd,
           exe_rt, dec_rs, dec_rt, wb_halt,
    input  pc_EN, fd_EN, de_EN, em_EN, mw_EN, fd_flush, de_flush, em_flush,
           halt, stall_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dreq, mem_br_taken, exe_jump, exe_MemRd,
           exe_rt, dec_rs, dec_rt, wb_halt,
    output pc_EN, fd_EN, de_EN, em_EN, mw_EN, fd_flush, de_flush, em_flush,
           halt, stall_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller.
// Generates PC/pipeline-register enables and flushes for load-use bubbles,
// taken branches, jumps, and instruction/data memory waits; latches halt
// and runs a sticky stall watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined;
// otherwise stall_cnt/flush_cnt read as zero.
module pipeline_hazard_ctrl #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input logic                  CLK,
  input logic                  RST,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Control vector layout: {pc_EN, fd_EN, de_EN, em_EN, mw_EN, fd_flush, de_flush, em_flush}
  localparam logic [7:0] CTRL_FREEZE   = 8'b00000_000;
  localparam logic [7:0] CTRL_BRANCH   = 8'b11111_111;
  localparam logic [7:0] CTRL_LOADUSE  = 8'b00111_010;
  localparam logic [7:0] CTRL_JUMP     = 8'b11111_110;
  localparam logic [7:0] CTRL_IMISS    = 8'b00111_100;
  localparam logic [7:0] CTRL_ADVANCE  = 8'b11111_000;

  localparam logic [7:0] LIMIT_C = 8'(STALL_LIMIT);

  state_e      state_q;
  state_e      state_d;
  logic [7:0]  ctrl_d;
  logic        load_use_d;
  logic        stalled_d;
  logic [7:0]  wd_q;
  logic [7:0]  wd_d;
  logic        timeout_q;

  // A load in execute whose nonzero destination feeds the decode instruction.
  assign load_use_d = hz.exe_MemRd && (hz.exe_rt != 5'd0) &&
                      ((hz.exe_rt == hz.dec_rs) || (hz.exe_rt == hz.dec_rt));

  // Next-state and control decode; priority order inside the active states matters.
  always_comb begin
    state_d = state_q;
    ctrl_d  = CTRL_FREEZE;
    if (RST) begin
      state_d = ST_RUN;
      ctrl_d  = CTRL_FREEZE;
    end else begin
      case (state_q)
        ST_RUN, ST_DWAIT: begin
          if (hz.wb_halt) begin
            state_d = ST_HALTED;
            ctrl_d  = CTRL_FREEZE;
          end else if (!hz.dhit && (hz.mem_dreq || (state_q == ST_DWAIT))) begin
            // Data access outstanding: hold everything, including a pending branch.
            state_d = ST_DWAIT;
            ctrl_d  = CTRL_FREEZE;
          end else begin
            state_d = ST_RUN;
            if (hz.mem_br_taken) begin
              ctrl_d = CTRL_BRANCH;
            end else if (load_use_d) begin
              ctrl_d = CTRL_LOADUSE;
            end else if (hz.exe_jump) begin
              ctrl_d = CTRL_JUMP;
            end else if (!hz.ihit) begin
              ctrl_d = CTRL_IMISS;
            end else begin
              ctrl_d = CTRL_ADVANCE;
            end
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
          ctrl_d  = CTRL_FREEZE;
        end
        default: begin
          state_d = ST_RUN;
          ctrl_d  = CTRL_FREEZE;
        end
      endcase
    end
  end

  assign hz.pc_EN    = ctrl_d[7];
  assign hz.fd_EN    = ctrl_d[6];
  assign hz.de_EN    = ctrl_d[5];
  assign hz.em_EN    = ctrl_d[4];
  assign hz.mw_EN    = ctrl_d[3];
  assign hz.fd_flush = ctrl_d[2];
  assign hz.de_flush = ctrl_d[1];
  assign hz.em_flush = ctrl_d[0];
  assign hz.halt     = (state_q == ST_HALTED);
  assign hz.stall_timeout = timeout_q;

  // A frozen PC outside HALTED counts as a stalled cycle.
  assign stalled_d = !ctrl_d[7] && (state_q != ST_HALTED);

  // Watchdog next value: clear on PC advance, saturating count while stalled.
  always_comb begin
    wd_d = wd_q;
    if (ctrl_d[7]) begin
      wd_d = 8'd0;
    end else if (stalled_d) begin
      wd_d = (wd_q == 8'hFF) ? 8'hFF : (wd_q + 8'd1);
    end else begin
      wd_d = wd_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Watchdog counter and its sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_q      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_q || (wd_d >= LIMIT_C);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Wrapping performance counters for stalled and flushing cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stalled_d) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (|ctrl_d[2:0]) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (STALL_LIMIT=4).
// A driver applies directed then random stimulus each cycle and pushes the
// reference model's expectation; a monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic        halt;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.STALL_LIMIT(LIMIT)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_no   = 0;

  // Reference model state, kept as plain booleans and integers.
  bit          m_halted = 1'b0;
  bit          m_waiting = 1'b0;
  int          m_wd = 0;
  bit          m_to = 1'b0;
  int unsigned m_sc = 0;
  int unsigned m_fc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_no, act, expv);
    end
  endtask

  // Apply one cycle of inputs and record what the controller must do.
  task automatic cyc(input bit rst, input bit ih, input bit dh, input bit dq,
                     input bit br, input bit jp, input bit mr,
                     input logic [4:0] ert, input logic [4:0] rs,
                     input logic [4:0] rt, input bit wh);
    exp_t       e;
    logic [7:0] c;
    bit         pc, fl;
    @(negedge CLK);
    RST             = rst;
    hz.ihit         = ih;
    hz.dhit         = dh;
    hz.mem_dreq     = dq;
    hz.mem_br_taken = br;
    hz.exe_jump     = jp;
    hz.exe_MemRd    = mr;
    hz.exe_rt       = ert;
    hz.dec_rs       = rs;
    hz.dec_rt       = rt;
    hz.wb_halt      = wh;

    // {pc, fd, de, em, mw, fd_flush, de_flush, em_flush}
    if (rst || m_halted)                          c = 8'b00000000;
    else if (wh)                                  c = 8'b00000000;
    else if (!dh && (dq || m_waiting))            c = 8'b00000000;
    else if (br)                                  c = 8'b11111111;
    else if (mr && ert != 5'd0 && (ert == rs || ert == rt)) c = 8'b00111010;
    else if (jp)                                  c = 8'b11111110;
    else if (!ih)                                 c = 8'b00111100;
    else                                          c = 8'b11111000;

    e.ctrl = c;
    e.halt = m_halted;
    e.to   = m_to;
`ifdef HAZARD_PERF_EN
    e.sc = m_sc;
    e.fc = m_fc;
`else
    e.sc = 32'd0;
    e.fc = 32'd0;
`endif
    exp_q.push_back(e);

    pc = c[7];
    fl = |c[2:0];
    if (rst) begin
      m_halted = 1'b0; m_waiting = 1'b0; m_wd = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
    end else begin
      if (pc) m_wd = 0;
      else if (!m_halted) m_wd = (m_wd >= 255) ? 255 : m_wd + 1;
      if (m_wd >= LIMIT) m_to = 1'b1;
      if (!pc && !m_halted) m_sc++;
      if (fl) m_fc++;
      if (!m_halted) begin
        if (wh) m_halted = 1'b1;
        else m_waiting = !dh && (dq || m_waiting);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl", {56'd0, hz.pc_EN, hz.fd_EN, hz.de_EN, hz.em_EN, hz.mw_EN,
                     hz.fd_flush, hz.de_flush, hz.em_flush}, {56'd0, e.ctrl});
        chk("halt", {63'd0, hz.halt}, {63'd0, e.halt});
        chk("stall_timeout", {63'd0, hz.stall_timeout}, {63'd0, e.to});
        chk("counters", {hz.stall_cnt, hz.flush_cnt}, {e.sc, e.fc});
        cyc_no++;
      end
    end
  end

  // Driver: directed scenarios first, then randomized traffic.
  initial begin
    hz.ihit = 1'b1; hz.dhit = 1'b1; hz.mem_dreq = 1'b0; hz.mem_br_taken = 1'b0;
    hz.exe_jump = 1'b0; hz.exe_MemRd = 1'b0; hz.exe_rt = 5'd0; hz.dec_rs = 5'd0;
    hz.dec_rt = 5'd0; hz.wb_halt = 1'b0;

    cyc(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);
    // Load-use on rs, then hazard gone; exe_rt=0 never stalls.
    cyc(0, 1, 1, 0, 0, 0, 1, 5'd2, 5'd2, 5'd7, 0);
    idle(1);
    cyc(0, 1, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 1, 1, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0);
    // Data wait for three cycles, then dhit with a pending taken branch.
    cyc(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 1, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    // Branch together with a load-use hazard: flush wins.
    cyc(0, 1, 1, 0, 1, 0, 1, 5'd4, 5'd4, 5'd4, 0);
    cyc(0, 1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // Halt, then activity is ignored, then reset.
    cyc(0, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    for (int i = 0; i < 4; i++)
      cyc(0, i[0], !i[0], 1, i[1], 1, 1, 5'd1, 5'd1, 5'd1, i[0]);
    cyc(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    // Watchdog: ihit held low, timeout stays set after recovery.
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(3);
    cyc(1, 1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    // Reset in the middle of a data wait.
    cyc(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(1, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 1, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);

    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(99) < 3), ($urandom_range(99) < 80), ($urandom_range(99) < 60),
          ($urandom_range(99) < 30), ($urandom_range(99) < 12), ($urandom_range(99) < 12),
          ($urandom_range(99) < 35), 5'($urandom_range(3)), 5'($urandom_range(3)),
          5'($urandom_range(3)), ($urandom_range(99) < 2));
    end

    @(negedge CLK);
    @(negedge CLK);
    #4;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
